simd32_inst_fetch: RTL and testbench

Instruction fetch and issue unit driving the `simd32_top` decoder port. On a start command it reads a contiguous instruction program from a synchronous instruction memory, buffers words in a small prefetch FIFO, and presents them one at a time on `inst`, honouring the decoder's `decoder_stall` backpressure. It is the RTL producer side of the decoder's instruction interface.

---
 rtl/simd32_inst_fetch.sv | 204 ++++++++++++++++++++
 tb/tb_simd32_inst_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd32_inst_fetch.sv
// Instruction fetch/issue unit: prefetches a program into a small FIFO and issues it to the decoder.
// Optional stall counter enabled by defining SIMD32_IFETCH_PERF_EN.
module simd32_inst_fetch #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [1:0]        start_wf,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic [1:0]        wavefront_num,
    input  logic              decoder_stall,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [1:0]        wf_q, wf_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [1:0]        wavefront_q, wavefront_d;
    logic [31:0]       fifo_mem [FIFO_DEPTH];

    logic        rd_en;
    logic        start_accept;
    logic        credit;
    logic        consume;
    logic        load;
    logic        head_valid;
    logic [31:0] head_data;
    logic        push;
    logic        pop;

    assign credit  = (count_q + {{(CNT_W-1){1'b0}}, inflight_q}) < CNT_W'(FIFO_DEPTH);
    assign consume = inst_valid_q && !decoder_stall;
    assign load    = !inst_valid_q || !decoder_stall;
    assign push    = inflight_q;

    // An empty FIFO bypasses the returning read straight to the output register.
    assign head_valid = (count_q != '0) || inflight_q;
    assign head_data  = (count_q == '0) ? imem_rdata : fifo_mem[rd_ptr_q];
    assign pop        = load && head_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        remaining_d  = remaining_q;
        wf_d         = wf_q;
        start_accept = 1'b0;
        rd_en        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_accept = 1'b1;
                    pc_d         = start_pc;
                    remaining_d  = start_len;
                    wf_d         = start_wf;
                    state_d      = (start_len == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (credit) begin
                    rd_en       = 1'b1;
                    pc_d        = pc_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((count_q == '0) && !inflight_q && (!inst_valid_q || consume)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        inflight_d = rd_en;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        wavefront_d  = wavefront_q;
        if (load) begin
            if (head_valid) begin
                inst_d       = head_data;
                inst_valid_d = 1'b1;
                wavefront_d  = wf_q;
            end else begin
                inst_d       = '0;
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            remaining_q  <= '0;
            wf_q         <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            wavefront_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            remaining_q  <= remaining_d;
            wf_q         <= wf_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            wavefront_q  <= wavefront_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef SIMD32_IFETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_accept) begin
            stall_cnt_d = '0;
        end else if (inst_valid_q && decoder_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

    assign imem_rd_en    = rd_en;
    assign imem_addr     = rd_en ? pc_q : '0;
    assign inst          = inst_q;
    assign inst_valid    = inst_valid_q;
    assign wavefront_num = wavefront_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

endmodule

// File: tb/tb_simd32_inst_fetch.sv
// Scoreboard bench for simd32_inst_fetch: expected reads/instructions queued at start,
// checked by a negedge monitor.
module tb_simd32_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_pc;
    logic [7:0]  start_len;
    logic [1:0]  start_wf;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  wavefront_num;
    logic        decoder_stall;
    logic        busy;
    logic        done;
    logic [31:0] stall_cycles;

`ifdef SIMD32_IFETCH_PERF_EN
    localparam logic [31:0] ExpStall = 32'd3;
`else
    localparam logic [31:0] ExpStall = 32'd0;
`endif

    simd32_inst_fetch #(
        .ADDR_W    (8),
        .LEN_W     (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_pc     (start_pc),
        .start_len    (start_len),
        .start_wf     (start_wf),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .wavefront_num(wavefront_num),
        .decoder_stall(decoder_stall),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] mem [256];
    logic [7:0]  exp_addr [$];
    logic [33:0] exp_inst [$];
    int          cons_cyc [$];
    int          issued, consumed, rd_total, busy_cnt, valid_cnt, a2_hold;
    int          s, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory; garbage on idle cycles.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        else            imem_rdata <= 32'hDEAD_BEEF;
    end

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("outstanding_le_depth",
                32'((issued - consumed - int'(inst_valid)) <= 4), 32'd1);
            if (busy) busy_cnt++;
            if (inst_valid) valid_cnt++;
            if (inst_valid && inst == 32'hA000_0002) a2_hold++;
            if (!inst_valid) chk("nop_when_invalid", inst, 32'h0);
            if (imem_rd_en) begin
                issued++;
                rd_total++;
                if (exp_addr.size() == 0) begin
                    chk("unexpected_read", {24'h0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("read_addr", {24'h0, imem_addr}, {24'h0, exp_addr.pop_front()});
                end
            end
            if (inst_valid && !decoder_stall) begin
                consumed++;
                cons_cyc.push_back(cyc);
                if (exp_inst.size() == 0) begin
                    chk("unexpected_inst", inst, 32'hFFFF_FFFF);
                end else begin
                    logic [33:0] e;
                    e = exp_inst.pop_front();
                    chk("inst", inst, e[31:0]);
                    chk("wavefront", {30'h0, wavefront_num}, {30'h0, e[33:32]});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_cycle(input int n);
        while (cyc < n) next_cycle();
    endtask

    task automatic do_start(input logic [7:0] pc, input logic [7:0] len, input logic [1:0] wf);
        logic [7:0] a;
        cons_cyc.delete();
        for (int i = 0; i < int'(len); i++) begin
            a = pc + 8'(i);
            exp_addr.push_back(a);
            exp_inst.push_back({wf, mem[a]});
        end
        start     = 1'b1;
        start_pc  = pc;
        start_len = len;
        start_wf  = wf;
        s = cyc;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic raw_start(input logic [7:0] pc, input logic [7:0] len, input logic [1:0] wf);
        start     = 1'b1;
        start_pc  = pc;
        start_len = len;
        start_wf  = wf;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'h0, 32'h1);
            done_cyc = -1;
        end else begin
            @(negedge clk);
            chk("done_one_cycle", {31'h0, done}, 32'h0);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {24'hC30000, 8'(i)};
        for (int i = 0; i < 5; i++) mem[8'h10 + i] = 32'hA000_0001 + 32'(i);
        reset = 1'b1;
        start = 1'b0;
        start_pc = '0;
        start_len = '0;
        start_wf = '0;
        decoder_stall = 1'b0;
        issued = 0; consumed = 0; rd_total = 0; busy_cnt = 0; valid_cnt = 0; a2_hold = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Basic program, no stall
        do_start(8'h10, 8'd5, 2'd2);
        wait_done(50);
        chk("t1_num_consumed", 32'(cons_cyc.size()), 32'd5);
        if (cons_cyc.size() == 5) begin
            chk("t1_first_issue_cycle", 32'(cons_cyc[0]), 32'(s + 3));
            chk("t1_last_issue_cycle", 32'(cons_cyc[4]), 32'(s + 7));
        end
        chk("t1_done_cycle", 32'(done_cyc), 32'(s + 8));
        chk("t1_stall_cycles", stall_cycles, 32'h0);

        // Same program with decoder stall over cycles s+4..s+6
        a2_hold = 0;
        do_start(8'h10, 8'd5, 2'd2);
        go_cycle(s + 4);
        decoder_stall = 1'b1;
        go_cycle(s + 7);
        decoder_stall = 1'b0;
        wait_done(50);
        chk("t2_num_consumed", 32'(cons_cyc.size()), 32'd5);
        if (cons_cyc.size() == 5) begin
            chk("t2_a1_cycle", 32'(cons_cyc[0]), 32'(s + 3));
            chk("t2_a2_cycle", 32'(cons_cyc[1]), 32'(s + 7));
            chk("t2_a5_cycle", 32'(cons_cyc[4]), 32'(s + 10));
        end
        chk("t2_a2_hold", 32'(a2_hold), 32'd4);
        chk("t2_done_cycle", 32'(done_cyc), 32'(s + 11));
        chk("t2_stall_cycles", stall_cycles, ExpStall);

        // Address wrap
        do_start(8'hFE, 8'd4, 2'd0);
        chk("t3_stall_cleared", stall_cycles, 32'h0);
        wait_done(50);
        chk("t3_num_consumed", 32'(cons_cyc.size()), 32'd4);
        chk("t3_reads_left", 32'(exp_addr.size()), 32'd0);
        chk("t3_done_cycle", 32'(done_cyc), 32'(s + 7));

        // Zero-length program
        busy_cnt = 0;
        rd_total = 0;
        do_start(8'h30, 8'd0, 2'd1);
        wait_done(20);
        chk("t4_done_cycle", 32'(done_cyc), 32'(s + 1));
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd1);
        chk("t4_reads", 32'(rd_total), 32'd0);

        // Reset mid-program
        do_start(8'h20, 8'd8, 2'd3);
        for (int i = 0; i < 20 && cons_cyc.size() < 2; i++) next_cycle();
        chk("t5_two_issued", 32'(cons_cyc.size()), 32'd2);
        reset = 1'b1;
        exp_addr.delete();
        exp_inst.delete();
        issued = 0;
        consumed = 0;
        #1;
        chk("t5_rd_en", {31'h0, imem_rd_en}, 32'h0);
        chk("t5_addr", {24'h0, imem_addr}, 32'h0);
        chk("t5_inst", inst, 32'h0);
        chk("t5_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t5_wavefront", {30'h0, wavefront_num}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_done", {31'h0, done}, 32'h0);
        chk("t5_stall_cycles", stall_cycles, 32'h0);
        next_cycle();
        reset = 1'b0;
        valid_cnt = 0;
        repeat (12) next_cycle();
        chk("t5_no_valid_after_reset", 32'(valid_cnt), 32'd0);
        chk("t5_idle_after_reset", {31'h0, busy}, 32'h0);
        do_start(8'h00, 8'd1, 2'd2);
        wait_done(30);
        chk("t5_restart_consumed", 32'(cons_cyc.size()), 32'd1);
        chk("t5_restart_done_cycle", 32'(done_cyc), 32'(s + 4));

        // Start pulses while busy are ignored
        do_start(8'h10, 8'd5, 2'd1);
        go_cycle(s + 2);
        raw_start(8'h40, 8'd3, 2'd3);
        go_cycle(s + 5);
        raw_start(8'h50, 8'd0, 2'd0);
        wait_done(50);
        chk("t6_num_consumed", 32'(cons_cyc.size()), 32'd5);
        chk("t6_done_cycle", 32'(done_cyc), 32'(s + 8));
        chk("t6_reads_left", 32'(exp_addr.size()), 32'd0);
        chk("t6_insts_left", 32'(exp_inst.size()), 32'd0);
        repeat (3) next_cycle();
        chk("t6_idle", {31'h0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
